// File: rtl/noc_pkg.sv
// Shared packet-format definitions for the NoC router and its local injector.
// Packet layout: [15:8] payload, [7:4] signed dx hop offset, [3:0] signed dy hop offset.
// Forwarding stages slice packets with the same field constants defined here.
package noc_pkg;

  localparam int PKT_W       = 16;
  localparam int PAYLOAD_MSB = 15;
  localparam int PAYLOAD_LSB = 8;
  localparam int DX_MSB      = 7;
  localparam int DX_LSB      = 4;
  localparam int DY_MSB      = 3;
  localparam int DY_LSB      = 0;
  localparam int COORD_W     = 3;
  localparam int OFS_W       = 4;
  localparam int PAYLOAD_W   = PAYLOAD_MSB - PAYLOAD_LSB + 1;

  // Assemble a packet from its fields; offsets are already two's complement.
  function automatic logic [PKT_W-1:0] build_pkt(input logic [PAYLOAD_W-1:0] payload,
                                                 input logic [OFS_W-1:0]     dx,
                                                 input logic [OFS_W-1:0]     dy);
    return {payload, dx, dy};
  endfunction

endpackage

// File: rtl/noc_sync_fifo.sv
// Synchronous FIFO with first-word fall-through output from the registered array.
// Latency: a push at edge N is visible on dout at cycle N+1; no same-cycle bypass.
// Backpressure: full/empty come from registered state only; push when full and pop when empty are ignored.
// Ports: clk, rst (sync, active-high), push/din, pop/dout, full, empty, level (0..DEPTH).
module noc_sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic [AW:0]      level
);

  logic [WIDTH-1:0] mem [DEPTH];
  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        push_en;
  logic        pop_en;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push_en = push && !full;
  assign pop_en  = pop && !empty;

  // Empty reads as zero so stale array contents never leak after reset.
  assign dout = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // Storage is not reset; emptiness is tracked purely by the pointers.
  always_ff @(posedge clk) begin
    if (push_en) begin
      mem[wr_ptr[AW-1:0]] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_en) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_en, pop_en})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/noc_local_injector.sv
// Local injector: encodes absolute-destination send requests into relative-offset packets for the router.
// Latency: request accepted at edge N appears on pkt_out with pkt_valid=1 in cycle N+1.
// Backpressure: req_ready drops while the FIFO is full; pkt_out/pkt_valid hold until pkt_ready.
// Ports: clk, rst (sync, active-high); req_valid/req_ready/req_dst_x/req_dst_y/req_payload request side;
//        pkt_out/pkt_valid/pkt_ready router side; sent_count packets handed over; fifo_level occupancy.
module noc_local_injector
  import noc_pkg::*;
#(
  parameter int MY_X  = 0,
  parameter int MY_Y  = 0,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [COORD_W-1:0]       req_dst_x,
  input  logic [COORD_W-1:0]       req_dst_y,
  input  logic [PAYLOAD_W-1:0]     req_payload,
  output logic [PKT_W-1:0]         pkt_out,
  output logic                     pkt_valid,
  input  logic                     pkt_ready,
  output logic [CNT_W-1:0]         sent_count,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam logic [OFS_W-1:0] MY_X_EXT = OFS_W'(MY_X);
  localparam logic [OFS_W-1:0] MY_Y_EXT = OFS_W'(MY_Y);

  logic [OFS_W-1:0] dx;
  logic [OFS_W-1:0] dy;
  logic [PKT_W-1:0] enc_pkt;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;

  // Zero-extend then subtract: coordinates are 0..7, so the 4-bit result is always in -7..+7.
  assign dx      = {1'b0, req_dst_x} - MY_X_EXT;
  assign dy      = {1'b0, req_dst_y} - MY_Y_EXT;
  assign enc_pkt = build_pkt(req_payload, dx, dy);

  assign req_ready = !fifo_full;
  assign pkt_valid = !fifo_empty;
  assign push      = req_valid && req_ready;
  assign pop       = pkt_valid && pkt_ready;

  noc_sync_fifo #(
    .WIDTH (PKT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (enc_pkt),
    .full  (fifo_full),
    .pop   (pop),
    .dout  (pkt_out),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  // Natural binary wrap: all-ones increments back to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      sent_count <= '0;
    end else if (pop) begin
      sent_count <= sent_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_noc_local_injector.sv
module tb_noc_local_injector;

  localparam int MY_X  = 2;
  localparam int MY_Y  = 1;
  localparam int DEPTH = 4;
  localparam int CNT_W = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_dst_x;
  logic [2:0]  req_dst_y;
  logic [7:0]  req_payload;
  logic [15:0] pkt_out;
  logic        pkt_valid;
  logic        pkt_ready;
  logic [CNT_W-1:0] sent_count;
  logic [2:0]  fifo_level;

  int nchk = 0;
  int nerr = 0;

  // Reference model: queue of packets the router has yet to take, and packets taken mod 2^CNT_W.
  logic [15:0] mq[$];
  int          mcnt = 0;
  bit          last_acc;

  noc_local_injector #(
    .MY_X (MY_X), .MY_Y (MY_Y), .DEPTH (DEPTH), .CNT_W (CNT_W)
  ) dut (
    .clk (clk), .rst (rst),
    .req_valid (req_valid), .req_ready (req_ready),
    .req_dst_x (req_dst_x), .req_dst_y (req_dst_y), .req_payload (req_payload),
    .pkt_out (pkt_out), .pkt_valid (pkt_valid), .pkt_ready (pkt_ready),
    .sent_count (sent_count), .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] enc(input logic [7:0] p, input int x, input int y);
    int dx;
    int dy;
    dx = (x - MY_X) & 15;
    dy = (y - MY_Y) & 15;
    return {p, 4'(dx), 4'(dy)};
  endfunction

  function automatic logic [15:0] model_head();
    if (mq.size() == 0) return 16'h0000;
    return mq[0];
  endfunction

  // Advance one clock, updating the model from the inputs seen at that edge.
  task automatic tick();
    bit acc;
    bit pp;
    @(posedge clk);
    acc = req_valid && (mq.size() < DEPTH);
    pp  = pkt_ready && (mq.size() > 0);
    if (rst) begin
      mq.delete();
      mcnt = 0;
      acc  = 0;
    end else begin
      if (pp) begin
        void'(mq.pop_front());
        mcnt = (mcnt + 1) % (1 << CNT_W);
      end
      if (acc) mq.push_back(enc(req_payload, int'(req_dst_x), int'(req_dst_y)));
    end
    last_acc = acc;
    #1;
  endtask

  task automatic rand_req();
    req_dst_x   = 3'($urandom_range(0, 7));
    req_dst_y   = 3'($urandom_range(0, 7));
    req_payload = 8'($urandom_range(0, 255));
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; pkt_ready = 1'b0;
    req_dst_x = '0; req_dst_y = '0; req_payload = '0;
    tick();
    rst = 1'b0;
    nchk++;
    if (pkt_valid !== 1'b0 || req_ready !== 1'b1 || sent_count !== '0 ||
        fifo_level !== 3'd0 || pkt_out !== 16'h0000) begin
      nerr++;
      $display("FAIL reset: valid=%b ready=%b sent=%0d level=%0d out=%h, required 0 1 0 0 0000",
               pkt_valid, req_ready, sent_count, fifo_level, pkt_out);
    end
  endtask

  task automatic test_single();
    pkt_ready = 1'b1; req_valid = 1'b1;
    req_dst_x = 3'd5; req_dst_y = 3'd1; req_payload = 8'hA5;
    tick();
    req_valid = 1'b0;
    nchk++;
    if (pkt_out !== 16'hA530 || pkt_valid !== 1'b1) begin
      nerr++;
      $display("FAIL single_pkt: out=%h valid=%b, required a530 1", pkt_out, pkt_valid);
    end
    tick();
    nchk++;
    if (pkt_valid !== 1'b0 || sent_count !== 4'd1) begin
      nerr++;
      $display("FAIL single_done: valid=%b sent=%0d, required 0 1", pkt_valid, sent_count);
    end
  endtask

  task automatic test_encoding();
    logic [7:0] p;
    req_valid = 1'b1;
    req_dst_x = 3'd0; req_dst_y = 3'd4; req_payload = 8'h3C;
    tick();
    req_valid = 1'b0;
    nchk++;
    if (pkt_out !== 16'h3CE3) begin
      nerr++;
      $display("FAIL enc_neg_dx: out=%h, required 3ce3", pkt_out);
    end
    tick();
    p = 8'($urandom_range(0, 255));
    req_valid = 1'b1;
    req_dst_x = 3'd2; req_dst_y = 3'd1; req_payload = p;
    tick();
    req_valid = 1'b0;
    nchk++;
    if (pkt_out !== {p, 8'h00} || pkt_valid !== 1'b1) begin
      nerr++;
      $display("FAIL enc_self: out=%h valid=%b, required %h 1", pkt_out, pkt_valid, {p, 8'h00});
    end
    tick();
    for (int i = 0; i < 24; i++) begin
      rand_req();
      req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      nchk++;
      if (pkt_out !== model_head() || pkt_valid !== 1'b1) begin
        nerr++;
        $display("FAIL enc_rand: dst=(%0d,%0d) out=%h, required %h", req_dst_x, req_dst_y,
                 pkt_out, model_head());
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] first;
    int start_cnt;
    int guard;
    start_cnt = mcnt;
    pkt_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rand_req();
      req_valid = 1'b1;
      nchk++;
      if (req_ready !== 1'b1) begin
        nerr++;
        $display("FAIL bp_ready_%0d: req_ready=%b, required 1", i, req_ready);
      end
      tick();
      if (i == 0) first = enc(req_payload, int'(req_dst_x), int'(req_dst_y));
    end
    rand_req();
    for (int i = 0; i < 3; i++) begin
      nchk++;
      if (req_ready !== 1'b0 || fifo_level !== 3'd4 || pkt_out !== first || pkt_valid !== 1'b1) begin
        nerr++;
        $display("FAIL bp_hold: ready=%b level=%0d out=%h, required 0 4 %h", req_ready,
                 fifo_level, pkt_out, first);
      end
      tick();
    end
    // Release: the held fifth request must be taken once a slot frees.
    pkt_ready = 1'b1;
    guard = 0;
    do begin
      tick();
      guard++;
    end while (!last_acc && guard < 10);
    req_valid = 1'b0;
    nchk++;
    if (!last_acc) begin
      nerr++;
      $display("FAIL bp_fifth: fifth request not accepted, required accept within 10 cycles");
    end
    for (int i = 0; i < 10 && mq.size() > 0; i++) begin
      nchk++;
      if (pkt_out !== mq[0] || pkt_valid !== 1'b1) begin
        nerr++;
        $display("FAIL bp_order: out=%h valid=%b, required %h 1", pkt_out, pkt_valid, mq[0]);
      end
      tick();
    end
    nchk++;
    if (sent_count !== CNT_W'((start_cnt + 5) % 16) || pkt_valid !== 1'b0) begin
      nerr++;
      $display("FAIL bp_count: sent=%0d valid=%b, required %0d 0", sent_count, pkt_valid,
               (start_cnt + 5) % 16);
    end
  endtask

  task automatic test_streaming();
    logic [15:0] prev;
    int c0;
    pkt_ready = 1'b1; req_valid = 1'b1;
    rand_req();
    prev = enc(req_payload, int'(req_dst_x), int'(req_dst_y));
    tick();
    c0 = mcnt;
    for (int i = 1; i <= 20; i++) begin
      rand_req();
      nchk++;
      if (fifo_level !== 3'd1 || pkt_valid !== 1'b1 || pkt_out !== prev ||
          sent_count !== CNT_W'((c0 + i - 1) % 16)) begin
        nerr++;
        $display("FAIL stream_%0d: level=%0d valid=%b out=%h sent=%0d, required 1 1 %h %0d", i,
                 fifo_level, pkt_valid, pkt_out, sent_count, prev, (c0 + i - 1) % 16);
      end
      prev = enc(req_payload, int'(req_dst_x), int'(req_dst_y));
      tick();
    end
    req_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    pkt_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rand_req();
      req_valid = 1'b1;
      tick();
    end
    req_valid = 1'b0;
    nchk++;
    if (fifo_level !== 3'd3) begin
      nerr++;
      $display("FAIL rmid_fill: level=%0d, required 3", fifo_level);
    end
    rst = 1'b1; pkt_ready = 1'b1; req_valid = 1'b1;
    tick();
    rst = 1'b0; req_valid = 1'b0;
    nchk++;
    if (pkt_valid !== 1'b0 || fifo_level !== 3'd0 || sent_count !== '0 || req_ready !== 1'b1) begin
      nerr++;
      $display("FAIL rmid_clear: valid=%b level=%0d sent=%0d ready=%b, required 0 0 0 1",
               pkt_valid, fifo_level, sent_count, req_ready);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      nchk++;
      if (pkt_valid !== 1'b0 || sent_count !== '0 || pkt_out !== 16'h0000) begin
        nerr++;
        $display("FAIL rmid_ghost: valid=%b sent=%0d out=%h, required 0 0 0000", pkt_valid,
                 sent_count, pkt_out);
      end
    end
  endtask

  task automatic test_count_wrap();
    int guard;
    pkt_ready = 1'b1; req_valid = 1'b1;
    guard = 0;
    while (mcnt != 15 && guard < 40) begin
      rand_req();
      tick();
      guard++;
    end
    nchk++;
    if (sent_count !== 4'hF) begin
      nerr++;
      $display("FAIL wrap_top: sent=%0d, required 15", sent_count);
    end
    tick();
    req_valid = 1'b0;
    nchk++;
    if (sent_count !== 4'h0) begin
      nerr++;
      $display("FAIL wrap_zero: sent=%0d, required 0", sent_count);
    end
    for (int i = 0; i < 4; i++) tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      rand_req();
      req_valid = ($urandom_range(0, 99) < 60);
      pkt_ready = ($urandom_range(0, 99) < 50);
      rst       = ($urandom_range(0, 99) < 2);
      nchk++;
      if (pkt_out !== model_head() || pkt_valid !== (mq.size() > 0) ||
          req_ready !== (mq.size() < DEPTH) || fifo_level !== 3'(mq.size()) ||
          sent_count !== CNT_W'(mcnt)) begin
        nerr++;
        $display("FAIL random_%0d: out=%h valid=%b ready=%b level=%0d sent=%0d, required %h %b %b %0d %0d",
                 i, pkt_out, pkt_valid, req_ready, fifo_level, sent_count, model_head(),
                 mq.size() > 0, mq.size() < DEPTH, mq.size(), mcnt);
      end
      tick();
    end
    rst = 1'b0; req_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_encoding();
    test_backpressure();
    test_streaming();
    test_reset_mid();
    test_count_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
